// File: rtl/huc_periph_pkg.sv
// Shared definitions for the HuC6280 on-chip peripherals: timer register map,
// control bit positions and timer FSM states.
package huc_periph_pkg;
  localparam logic TMR_CNT = 1'b0;
  localparam logic TMR_CTL = 1'b1;

  localparam int TIMER_PRESCALE_DEFAULT = 1024;

  localparam int CTL_EN      = 0;
  localparam int CTL_ONESHOT = 1;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } tmr_state_e;
endpackage

// File: rtl/huc_timer_prescaler.sv
// Free-running prescaler for the interval timer. Emits a one-cycle tick on the
// cycle its count sits at PRESCALE-1, and clears whenever run is low.
module huc_timer_prescaler #(
  parameter int PRESCALE = 1024,
  parameter int PS_W     = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && (cnt_q == LAST);
    cnt_d = cnt_q + PS_W'(1);
    if (!run || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/huc_timer.sv
// HuC6280 interval timer: 7-bit down-counter with reload, sticky active-low TIQ.
// Define HUC_TIMER_ONESHOT_EN to add the one-shot control bit (ctl bit 1).
module huc_timer
  import huc_periph_pkg::*;
#(
  parameter int PRESCALE = TIMER_PRESCALE_DEFAULT,
  parameter int PS_W     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CET_n,
  input  logic       A0,
  input  logic       we,
  input  logic       re,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  input  logic       tiq_ack,
  output logic       TIQ_n
);
  tmr_state_e state_q, state_d;
  logic [6:0] counter_q, counter_d;
  logic [6:0] reload_q, reload_d;
  logic       en_q, en_d;
  logic       tiq_n_q, tiq_n_d;
  logic [7:0] dout_q, dout_d;
  logic       oneshot_q;
  logic       wr, rd, ctl_wr, rld_wr, stop_wr, run, tick, underflow;
  logic       unused_din7;

  assign unused_din7 = d_in[7];

`ifdef HUC_TIMER_ONESHOT_EN
  logic oneshot_d;
  always_comb oneshot_d = ctl_wr ? d_in[CTL_ONESHOT] : oneshot_q;
  always_ff @(posedge clk) begin
    if (reset) oneshot_q <= 1'b0;
    else       oneshot_q <= oneshot_d;
  end
`else
  assign oneshot_q = 1'b0;
`endif

  // A simultaneous read and write is a write; d_out holds.
  assign wr      = !CET_n && we;
  assign rd      = !CET_n && re && !we;
  assign ctl_wr  = wr && (A0 == TMR_CTL);
  assign rld_wr  = wr && (A0 == TMR_CNT);
  assign stop_wr = ctl_wr && !d_in[CTL_EN];
  // Dropping run on the stopping edge clears the prescaler on that same edge.
  assign run       = (state_q == RUNNING) && !stop_wr;
  assign underflow = tick && (counter_q == '0);

  huc_timer_prescaler #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_ps (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = rld_wr ? d_in[6:0] : reload_q;
    en_d      = ctl_wr ? d_in[CTL_EN] : en_q;
    tiq_n_d   = tiq_n_q;
    dout_d    = dout_q;

    case (state_q)
      STOPPED: if (ctl_wr && d_in[CTL_EN]) begin
        state_d   = RUNNING;
        counter_d = reload_q;
      end
      RUNNING: if (stop_wr) begin
        state_d = STOPPED;
      end else if (tick) begin
        if (counter_q != '0) begin
          counter_d = counter_q - 7'd1;
        end else begin
          counter_d = reload_q;
          if (oneshot_q) begin
            state_d = STOPPED;
            en_d    = 1'b0;
          end
        end
      end
      default: state_d = STOPPED;
    endcase

    if (underflow)    tiq_n_d = 1'b0;
    else if (tiq_ack) tiq_n_d = 1'b1;

    if (rd) dout_d = (A0 == TMR_CTL) ? {6'b0, oneshot_q, en_q} : {1'b0, counter_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STOPPED;
      counter_q <= '0;
      reload_q  <= '0;
      en_q      <= 1'b0;
      tiq_n_q   <= 1'b1;
      dout_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      en_q      <= en_d;
      tiq_n_q   <= tiq_n_d;
      dout_q    <= dout_d;
    end
  end

  assign d_out = dout_q;
  assign TIQ_n = tiq_n_q;
endmodule

// File: tb/tb_huc_timer.sv
// Directed bench for huc_timer with PRESCALE=4: a register-access vector table
// followed by hand-timed sequences for period, ack, stop/restart and reload.
module tb_huc_timer;
  logic       clk = 1'b0;
  logic       reset, CET_n, A0, we, re, tiq_ack;
  logic [7:0] d_in, d_out;
  logic       TIQ_n;
  int         tests = 0, fails = 0, cyc_n = 0;
  int         e0, e2, e3, e4;

  always #5 clk = ~clk;

  huc_timer #(.PRESCALE(4), .PS_W(2)) dut (
    .clk(clk), .reset(reset), .CET_n(CET_n), .A0(A0), .we(we), .re(re),
    .d_in(d_in), .d_out(d_out), .tiq_ack(tiq_ack), .TIQ_n(TIQ_n)
  );

  typedef struct {
    string      nm;
    logic       cet_n, we, re, a0, ack;
    logic [7:0] din, exp_dout;
    logic       exp_tiq;
  } vec_t;
  vec_t v[16];

  task automatic cyc();
    @(posedge clk); #1; cyc_n++;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic chk_tiq(input string nm, input logic exp);
    chk(nm, {7'b0, TIQ_n}, {7'b0, exp});
  endtask

  task automatic idle();
    CET_n = 1'b1; we = 1'b0; re = 1'b0; tiq_ack = 1'b0; A0 = 1'b0; d_in = 8'h00;
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    CET_n = 1'b0; we = 1'b1; A0 = a; d_in = d; cyc(); idle();
  endtask

  task automatic rd(input logic a);
    CET_n = 1'b0; re = 1'b1; A0 = a; cyc(); idle();
  endtask

  task automatic ack();
    tiq_ack = 1'b1; cyc(); tiq_ack = 1'b0;
  endtask

  task automatic run_to(input int t);
    while (cyc_n < t) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
  endtask

  initial begin
    idle();
    do_reset();
    chk_tiq("reset_tiq", 1'b1);
    chk("reset_dout", d_out, 8'h00);

    //          nm             cet we re a0 ack din    dout   tiq
    v[0]  = '{"rd_cnt0",      0, 0, 1, 0, 0, 8'h00, 8'h00, 1};
    v[1]  = '{"wr_reload",    0, 1, 0, 0, 0, 8'hFF, 8'h00, 1};
    v[2]  = '{"rd_ctl0",      0, 0, 1, 1, 0, 8'h00, 8'h00, 1};
    v[3]  = '{"rd_cnt_noload",0, 0, 1, 0, 0, 8'h00, 8'h00, 1};
    v[4]  = '{"wr_en",        0, 1, 0, 1, 0, 8'h01, 8'h00, 1};
    v[5]  = '{"rd_cnt_loaded",0, 0, 1, 0, 0, 8'h00, 8'h7F, 1};
    v[6]  = '{"rd_ctl_en",    0, 0, 1, 1, 0, 8'h00, 8'h01, 1};
    v[7]  = '{"rd_no_ce",     1, 0, 1, 0, 0, 8'h00, 8'h01, 1};
    v[8]  = '{"we_re_stop",   0, 1, 1, 1, 0, 8'h00, 8'h01, 1};
    v[9]  = '{"rd_ctl_stop",  0, 0, 1, 1, 0, 8'h00, 8'h00, 1};
    v[10] = '{"rd_cnt_frozen",0, 0, 1, 0, 0, 8'h00, 8'h7F, 1};
    v[11] = '{"ack_idle",     1, 0, 0, 0, 1, 8'h00, 8'h7F, 1};
    v[12] = '{"wr_no_ce",     1, 1, 0, 1, 0, 8'h01, 8'h7F, 1};
    v[13] = '{"rd_ctl_no_ce", 0, 0, 1, 1, 0, 8'h00, 8'h00, 1};
    v[14] = '{"wr_bit1",      0, 1, 0, 1, 0, 8'h02, 8'h00, 1};
`ifdef HUC_TIMER_ONESHOT_EN
    v[15] = '{"rd_ctl_bit1",  0, 0, 1, 1, 0, 8'h00, 8'h02, 1};
`else
    v[15] = '{"rd_ctl_bit1",  0, 0, 1, 1, 0, 8'h00, 8'h00, 1};
`endif
    for (int i = 0; i < 16; i++) begin
      CET_n = v[i].cet_n; we = v[i].we; re = v[i].re; A0 = v[i].a0;
      tiq_ack = v[i].ack; d_in = v[i].din;
      cyc(); idle();
      chk({v[i].nm, "_dout"}, d_out, v[i].exp_dout);
      chk_tiq({v[i].nm, "_tiq"}, v[i].exp_tiq);
    end

    // Period: reload=3 -> TIQ 16 clks after enable, counter 3,2,1,0,3
    do_reset();
    wr(0, 8'd3);
    wr(1, 8'h01);
    e0 = cyc_n;
    CET_n = 1'b0; re = 1'b1; A0 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      case (n)
        2:  chk("cnt_3", d_out, 8'd3);
        6:  chk("cnt_2", d_out, 8'd2);
        10: chk("cnt_1", d_out, 8'd1);
        14: chk("cnt_0", d_out, 8'd0);
        15: chk_tiq("tiq_before_uf", 1'b1);
        16: chk_tiq("tiq_at_uf", 1'b0);
        18: chk("cnt_reloaded", d_out, 8'd3);
        default: ;
      endcase
    end
    idle();

    // Ack clears; ack coinciding with underflow loses
    ack();
    chk_tiq("ack_clear", 1'b1);
    run_to(e0 + 31);
    chk_tiq("tiq_pre_uf2", 1'b1);
    tiq_ack = 1'b1; cyc(); tiq_ack = 1'b0;
    chk_tiq("ack_vs_uf", 1'b0);
    ack();
    chk_tiq("ack_clear2", 1'b1);

    // Stop at counter=2, stays frozen with no TIQ
    run_to(e0 + 37);
    wr(1, 8'h00);
    CET_n = 1'b0; re = 1'b1; A0 = 1'b0;
    for (int n = 0; n < 50; n++) begin
      cyc();
      chk("stopped_cnt", d_out, 8'd2);
      chk_tiq("stopped_tiq", 1'b1);
    end
    idle();

    // Restart reloads and gives a full period; extra en writes change nothing
    wr(1, 8'h01);
    e2 = cyc_n;
    rd(0);
    chk("restart_cnt", d_out, 8'd3);
    run_to(e2 + 4);
    wr(1, 8'h01);
    cyc();
    wr(1, 8'h01);
    run_to(e2 + 15);
    chk_tiq("rewr_pre_uf", 1'b1);
    cyc();
    chk_tiq("rewr_uf", 1'b0);
    ack();
    rd(1);
    chk("rd_ctl_running", d_out, 8'h01);

    // Reload change mid-count, and reload write on an underflow edge
    wr(1, 8'h00);
    wr(0, 8'd5);
    wr(1, 8'h01);
    e3 = cyc_n;
    run_to(e3 + 9);
    wr(0, 8'd1);
    run_to(e3 + 23);
    chk_tiq("old_period_pre", 1'b1);
    cyc();
    chk_tiq("old_period_uf", 1'b0);
    ack();
    rd(0);
    chk("new_reload_cnt", d_out, 8'd1);
    run_to(e3 + 31);
    chk_tiq("short_pre1", 1'b1);
    cyc();
    chk_tiq("short_uf1", 1'b0);
    ack();
    run_to(e3 + 39);
    chk_tiq("short_pre2", 1'b1);
    wr(0, 8'd3);
    chk_tiq("short_uf2", 1'b0);
    ack();
    run_to(e3 + 47);
    chk_tiq("old_rld_pre", 1'b1);
    cyc();
    chk_tiq("old_rld_uf", 1'b0);
    ack();
    run_to(e3 + 63);
    chk_tiq("new_rld_pre", 1'b1);
    cyc();
    chk_tiq("new_rld_uf", 1'b0);

    // Reset mid-count with TIQ pending and a same-cycle enable write
    rd(0);
    chk("pre_reset_cnt", d_out, 8'd3);
    reset = 1'b1; CET_n = 1'b0; we = 1'b1; A0 = 1'b1; d_in = 8'h01;
    cyc();
    reset = 1'b0; idle();
    chk_tiq("rst_tiq", 1'b1);
    chk("rst_dout", d_out, 8'h00);
    rd(1);
    chk("rst_ctl", d_out, 8'h00);
    rd(0);
    chk("rst_cnt", d_out, 8'h00);
    repeat (20) cyc();
    chk_tiq("rst_no_run", 1'b1);

`ifdef HUC_TIMER_ONESHOT_EN
    do_reset();
    wr(1, 8'h03);
    e4 = cyc_n;
    run_to(e4 + 3);
    chk_tiq("os_pre", 1'b1);
    cyc();
    chk_tiq("os_uf", 1'b0);
    rd(1);
    chk("os_ctl", d_out, 8'h02);
    ack();
    run_to(e4 + 30);
    chk_tiq("os_no_more", 1'b1);
    rd(0);
    chk("os_cnt", d_out, 8'h00);
`else
    e4 = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
